// File: rtl/axil_map_initiator.sv
// Initiator end of the axil_map stream protocol: command stream in, sRA/sWA/sW/sR/sB channels out,
// in-order read results on a buffered rd stream. Define AXIL_INIT_STATS_EN to add n_wr/n_rd counters.
module axil_map_initiator #(
  parameter int N_ADDR  = 10,
  parameter int N_DATA  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_DATA+N_ADDR:0] cmd,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [N_ADDR-1:0]      sRA,
  output logic                   sRA_valid,
  input  logic                   sRA_ready,
  output logic [N_ADDR-1:0]      sWA,
  output logic                   sWA_valid,
  input  logic                   sWA_ready,
  output logic [N_DATA-1:0]      sW,
  output logic                   sW_valid,
  input  logic                   sW_ready,
  input  logic [N_DATA-1:0]      sR,
  input  logic                   sR_valid,
  output logic                   sR_ready,
  input  logic                   sB_valid,
  output logic                   sB_ready,
  output logic [N_DATA-1:0]      rd,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   idle
`ifdef AXIL_INIT_STATS_EN
  ,
  output logic [N_DATA-1:0]      n_wr,
  output logic [N_DATA-1:0]      n_rd
`endif
);

  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_HAZ, S_RD} state_t;

  state_t              state_reg, state_next;
  logic [N_ADDR-1:0]   sra_reg, swa_reg;
  logic [N_DATA-1:0]   sw_reg;
  logic                wa_pend_reg, w_pend_reg;
  logic [CW-1:0]       wr_out_reg, wr_out_next;
  logic [CW-1:0]       rd_out_reg, rd_out_next;
  logic [CW-1:0]       fifo_cnt_reg, fifo_cnt_next;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [N_DATA-1:0]   fifo_mem [MAX_OUT];

  logic                cmd_op;
  logic [N_DATA-1:0]   cmd_data;
  logic [N_ADDR-1:0]   cmd_addr;
  logic [CW:0]         rd_commit;
  logic                wr_credit, rd_credit;
  logic                cmd_fire, wa_fire, w_fire, ra_fire;
  logic                b_take, r_take, pop, wr_done;

  assign cmd_op   = cmd[N_DATA+N_ADDR];
  assign cmd_data = cmd[N_ADDR +: N_DATA];
  assign cmd_addr = cmd[N_ADDR-1:0];

  // Both credits gate acceptance, whatever the op, so cmd_ready never depends on the payload
  assign rd_commit = {1'b0, rd_out_reg} + {1'b0, fifo_cnt_reg};
  assign wr_credit = wr_out_reg < MAX_CNT;
  assign rd_credit = rd_commit < {1'b0, MAX_CNT};
  assign cmd_ready = !rst && (state_reg == S_IDLE) && wr_credit && rd_credit;

  assign sRA       = sra_reg;
  assign sWA       = swa_reg;
  assign sW        = sw_reg;
  assign sRA_valid = (state_reg == S_RD);
  assign sWA_valid = wa_pend_reg;
  assign sW_valid  = w_pend_reg;
  assign sR_ready  = 1'b1;
  assign sB_ready  = 1'b1;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wa_fire  = sWA_valid && sWA_ready;
  assign w_fire   = sW_valid && sW_ready;
  assign ra_fire  = sRA_valid && sRA_ready;
  assign b_take   = sB_valid && (wr_out_reg != '0);
  assign r_take   = sR_valid && (rd_out_reg != '0);
  assign rd_valid = (fifo_cnt_reg != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd       = fifo_mem[rd_ptr_reg];
  assign wr_done  = (state_reg == S_WR) && !(wa_pend_reg && !wa_fire) && !(w_pend_reg && !w_fire);
  assign idle     = (state_reg == S_IDLE) && (wr_out_reg == '0) && (rd_out_reg == '0) &&
                    (fifo_cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (cmd_fire) state_next = cmd_op ? S_WR : ((wr_out_reg != '0) ? S_HAZ : S_RD);
      S_WR:   if (wr_done) state_next = S_IDLE;
      S_HAZ:  if (wr_out_reg == '0) state_next = S_RD;
      S_RD:   if (ra_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Issue and response in the same cycle cancel out
  always_comb begin
    wr_out_next = wr_out_reg;
    if (wr_done && !b_take)      wr_out_next = wr_out_reg + ONE;
    else if (!wr_done && b_take) wr_out_next = wr_out_reg - ONE;
  end

  always_comb begin
    rd_out_next = rd_out_reg;
    if (ra_fire && !r_take)      rd_out_next = rd_out_reg + ONE;
    else if (!ra_fire && r_take) rd_out_next = rd_out_reg - ONE;
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    if (r_take && !pop)      fifo_cnt_next = fifo_cnt_reg + ONE;
    else if (!r_take && pop) fifo_cnt_next = fifo_cnt_reg - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      sra_reg      <= '0;
      swa_reg      <= '0;
      sw_reg       <= '0;
      wa_pend_reg  <= 1'b0;
      w_pend_reg   <= 1'b0;
      wr_out_reg   <= '0;
      rd_out_reg   <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wr_out_reg   <= wr_out_next;
      rd_out_reg   <= rd_out_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (cmd_fire && cmd_op) begin
        swa_reg     <= cmd_addr;
        sw_reg      <= cmd_data;
        wa_pend_reg <= 1'b1;
        w_pend_reg  <= 1'b1;
      end else begin
        if (wa_fire) wa_pend_reg <= 1'b0;
        if (w_fire)  w_pend_reg  <= 1'b0;
      end
      if (cmd_fire && !cmd_op) sra_reg <= cmd_addr;
      if (r_take) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Read-data buffer storage; occupancy is tracked above so it needs no reset
  always_ff @(posedge clk) begin
    if (r_take) fifo_mem[wr_ptr_reg] <= sR;
  end

`ifdef AXIL_INIT_STATS_EN
  logic [N_DATA-1:0] n_wr_reg, n_rd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_wr_reg <= '0;
      n_rd_reg <= '0;
    end else begin
      if (b_take) n_wr_reg <= n_wr_reg + 1'b1;
      if (r_take) n_rd_reg <= n_rd_reg + 1'b1;
    end
  end

  assign n_wr = n_wr_reg;
  assign n_rd = n_rd_reg;
`endif

endmodule
